chacha20_stream_ctrl: RTL
=========================

# chacha20_stream_ctrl

Sequencer that turns the ChaCha20 block core into a word-serial stream cipher. It takes a per-message 96-bit nonce and requests one 512-bit keystream block from the core at a time. It XORs incoming 32-bit data words against the buffered keystream and emits result words on a valid/ready stream. It sits between the card-data framing logic and the `chacha20core` instance, which it owns exclusively.

## Interface
Parameters:
- WAIT_TIMEOUT, 64: max cycles spent in WAIT before aborting the message; must be ≥ 32.

Ports:
- clk  in  1  clock; all logic on posedge.
- resetn  in  1  asynchronous, active-low reset.
- msg_start  in  1  start pulse; sampled only in IDLE.
- msg_nonce  in  96  message nonce; latched with msg_start.
- busy  out  1  high whenever state ≠ IDLE.
- err  out  1  one-cycle pulse on WAIT timeout.
- s_valid  in  1  input word valid.
- s_data  in  32  input word.
- s_last  in  1  final word of the message.
- s_ready  out  1  input accept.
- m_valid  out  1  output word valid.
- m_data  out  32  s_data XOR keystream word.
- m_last  out  1  copy of s_last for this word.
- m_ready  in  1  output accept.
- core_enable  out  1  core start; one-cycle pulse.
- core_nonce  out  96  per-block nonce to the core.
- core_cipher  in  512  core keystream block.
- core_ready  in  1  core done pulse.

## Operation
- Registers:
  - nonce_base (96b)
  - blk_idx (32b)
  - ks buffer (16×32b)
  - word_idx (4b)
  - timeout counter (7b minimum, sized for WAIT_TIMEOUT)
- Per-block nonce: core_nonce = {nonce_base[95:32], nonce_base[31:0] + blk_idx}, mod 2^32, so the low word wraps silently.
- core_nonce is registered and held stable from the REQ cycle until the core_ready capture.
- Keystream word order: word 0 = core_cipher[511:480], word 15 = core_cipher[31:0].
- IDLE:
  - On msg_start: latch msg_nonce, clear blk_idx and word_idx, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - core_enable = 1 for exactly this cycle; go to WAIT.
  - Clear the timeout counter.
- WAIT:
  - On core_ready: capture core_cipher into ks, set word_idx = 0, go to STREAM.
  - Otherwise increment the timeout counter.
  - When the counter reaches WAIT_TIMEOUT: pulse err, go to IDLE, discard the message.
- STREAM:
  - s_ready = (!m_valid || m_ready).
  - On an s_valid && s_ready transfer: m_data <= s_data ^ ks[word_idx]; m_last <= s_last; m_valid <= 1; word_idx++.
  - After the transfer, if s_last: go to IDLE; unused keystream words are discarded.
  - Else if word_idx was 15: blk_idx++, go to REQ.
- Output register:
  - m_valid clears on m_ready when no new transfer occurs in the same cycle.
  - A simultaneous drain and new transfer keeps m_valid = 1 with the new data.
  - The output register operates independently of state, so a pending word may drain while the FSM is in IDLE or REQ.
- s_ready is 0 in every state other than STREAM.
- Boundary cases:
  - msg_start while busy: ignored.
  - core_ready outside WAIT: ignored.
  - s_last on word 15: go to IDLE, no new request.
  - blk_idx wraps at 2^32 without error.
- Reset (async, any time):
  - State → IDLE; all counters, nonce_base, ks and core_nonce → 0.
  - Outputs → 0: busy, err, s_ready, m_valid, m_data, m_last, core_enable.

## Timing
- Cycle 0: msg_start in IDLE.
- Cycle 1: REQ, core_enable = 1.
- Cycle 2 onward: WAIT.
- Cycle after core_ready (call it C): STREAM, and s_ready may be high that cycle.
- Throughput in STREAM is one word per cycle while m_ready is held high.
- An accepted word appears on m_data in the next cycle, so first-word latency is 1 cycle after acceptance.
- Between consecutive blocks, s_ready is low for REQ (1 cycle) + WAIT (core latency, 1 cycle minimum).
- The err pulse occurs in the cycle after the timeout counter hits WAIT_TIMEOUT; busy drops in that same cycle.

## Test plan
- Bench stub core: returns core_ready 3 cycles after core_enable, with cipher word i = core_nonce[31:0] ^ i.
- Single word:
  - Stimulus: nonce 96'h0…0000_0100, s_data 32'hFFFF_0000 with s_last, m_ready = 1.
  - Required: m_data 32'hFFFF_0100, m_last = 1, one core_enable, busy drops after the transfer.
- Block rollover:
  - Stimulus: 20 back-to-back words of 0, last on word 20.
  - Required: second core_nonce low word = base+1; word 16 output = base+1; s_ready low during the REQ/WAIT gap; exactly 2 core_enable pulses.
- Backpressure:
  - Stimulus: m_ready toggles 1/0 every cycle.
  - Required: no word lost or duplicated; s_ready tracks !m_valid || m_ready.
- Counter wrap:
  - Stimulus: nonce low word 32'hFFFF_FFFF, 17 words.
  - Required: second block core_nonce low word = 0, upper 64 bits unchanged.
- Timeout and reset:
  - Timeout stimulus: stub never returns core_ready.
  - Timeout required: err pulses exactly once, WAIT_TIMEOUT + 1 cycles after REQ; state is IDLE; s_ready never asserts.
  - Reset stimulus: resetn asserted mid-STREAM.
  - Reset required: all outputs 0 immediately; a following msg_start works normally.

Source files
------------

// File: rtl/chacha20_stream_ctrl.sv
// Word-serial ChaCha20 stream sequencer: requests 512-bit keystream blocks
// from the core and XORs them against a 32-bit valid/ready data stream.
module chacha20_stream_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         msg_start,
    input  logic [95:0]  msg_nonce,
    output logic         busy,
    output logic         err,
    input  logic         s_valid,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    output logic         s_ready,
    output logic         m_valid,
    output logic [31:0]  m_data,
    output logic         m_last,
    input  logic         m_ready,
    output logic         core_enable,
    output logic [95:0]  core_nonce,
    input  logic [511:0] core_cipher,
    input  logic         core_ready
);

    localparam int unsigned CNT_W = ($clog2(WAIT_TIMEOUT + 1) > 7) ? $clog2(WAIT_TIMEOUT + 1) : 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_STREAM
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [95:0]        nonce_base;
    logic [31:0]        blk_idx;
    logic [31:0]        ks [16];
    logic [3:0]         word_idx;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               xfer;
    logic               timeout_hit;

    assign busy        = (state != ST_IDLE);
    assign core_enable = (state == ST_REQ);
    assign s_ready     = (state == ST_STREAM) && (!m_valid || m_ready);
    assign xfer        = s_valid && s_ready;
    // Fires on the last WAIT cycle so err lands WAIT_TIMEOUT+1 cycles after REQ.
    assign timeout_hit = (tmo_cnt == CNT_W'(WAIT_TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (msg_start) state_nxt = ST_REQ;
            ST_REQ:    state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (core_ready)       state_nxt = ST_STREAM;
                else if (timeout_hit) state_nxt = ST_IDLE;
            end
            ST_STREAM: begin
                if (xfer) begin
                    if (s_last)                 state_nxt = ST_IDLE;
                    else if (word_idx == 4'd15) state_nxt = ST_REQ;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            nonce_base <= '0;
            blk_idx    <= '0;
            word_idx   <= '0;
            tmo_cnt    <= '0;
            core_nonce <= '0;
            err        <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) ks[i] <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (msg_start) begin
                        nonce_base <= msg_nonce;
                        blk_idx    <= '0;
                        word_idx   <= '0;
                        core_nonce <= msg_nonce;
                    end
                end
                ST_REQ: tmo_cnt <= '0;
                ST_WAIT: begin
                    if (core_ready) begin
                        for (int unsigned i = 0; i < 16; i++) ks[i] <= core_cipher[32*(15-i) +: 32];
                        word_idx <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                        if (timeout_hit) err <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (xfer) begin
                        word_idx <= word_idx + 4'd1;
                        if (!s_last && word_idx == 4'd15) begin
                            blk_idx    <= blk_idx + 32'd1;
                            core_nonce <= {nonce_base[95:32], nonce_base[31:0] + blk_idx + 32'd1};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output holding register drains independently of the FSM state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (xfer) begin
            m_valid <= 1'b1;
            m_data  <= s_data ^ ks[word_idx];
            m_last  <= s_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
